// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operands and start going in, quotient,
// remainder and status coming out, plus the FSM state exposed for checkers.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic             ctrl_SIGNED;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output ctrl_DIV, ctrl_SIGNED, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy, dbg_state
  );

  modport slave (
    input  ctrl_DIV, ctrl_SIGNED, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy, dbg_state
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with signed/unsigned
// modes and single-cycle completion for divide-by-zero and signed overflow.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clock,
  input  logic         reset,
  seq_divider_if.slave bus
);
  // Handshake: ctrl_DIV is accepted on any rising edge where busy is low (IDLE or DONE)
  // and ignored while busy; there is no backpressure. data_resultRDY is a one-cycle
  // pulse that marks data_result/data_remainder/data_exception as freshly valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] rq;
  logic [WIDTH-1:0]   a_raw, b_raw;
  logic               sgn;
  logic [WIDTH-1:0]   result_q, remainder_q;
  logic               exception_q;

  logic               start;
  logic [WIDTH-1:0]   a_in_mag, b_mag;
  logic               div_zero, ovf, exc_now, last_step;
  logic [WIDTH+1:0]   trial;
  logic               fits;
  logic [2*WIDTH-1:0] rq_step;
  logic [WIDTH-1:0]   q_mag, r_mag;
  logic               neg_q, neg_r;

  assign start = bus.ctrl_DIV && (state != RUN);

  assign a_in_mag = (bus.ctrl_SIGNED && bus.data_operandA[WIDTH-1]) ?
                    -bus.data_operandA : bus.data_operandA;
  assign b_mag    = (sgn && b_raw[WIDTH-1]) ? -b_raw : b_raw;

  assign div_zero  = (b_raw == '0);
  assign ovf       = sgn && (a_raw == MOST_NEG) && (b_raw == '1);
  assign exc_now   = (cnt == '0) && (div_zero || ovf);
  assign last_step = (cnt == CNT_W'(WIDTH));

  // Trial subtract uses the shifted-out MSB too, since 2*rem can exceed WIDTH bits.
  assign trial   = {1'b0, rq[2*WIDTH-1:WIDTH-1]} - {2'b00, b_mag};
  assign fits    = !trial[WIDTH+1];
  assign rq_step = fits ? {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1}
                        : {rq[2*WIDTH-2:0], 1'b0};

  assign q_mag = rq[WIDTH-1:0];
  assign r_mag = rq[2*WIDTH-1:WIDTH];
  assign neg_q = sgn && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
  assign neg_r = sgn && a_raw[WIDTH-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ctrl_DIV) state_nxt = RUN;
      RUN:     if (exc_now || last_step) state_nxt = DONE;
      DONE:    state_nxt = bus.ctrl_DIV ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rq          <= '0;
      a_raw       <= '0;
      b_raw       <= '0;
      sgn         <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exception_q <= 1'b0;
    end else if (start) begin
      a_raw <= bus.data_operandA;
      b_raw <= bus.data_operandB;
      sgn   <= bus.ctrl_SIGNED;
      cnt   <= '0;
      rq    <= {{WIDTH{1'b0}}, a_in_mag};
    end else if (state == RUN) begin
      if (exc_now) begin
        exception_q <= 1'b1;
        if (div_zero) begin
          result_q    <= '1;
          remainder_q <= a_raw;
        end else begin
          result_q    <= a_raw;
          remainder_q <= '0;
        end
      end else if (last_step) begin
        exception_q <= 1'b0;
        result_q    <= neg_q ? -q_mag : q_mag;
        remainder_q <= neg_r ? -r_mag : r_mag;
      end else begin
        rq  <= rq_step;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = remainder_q;
  assign bus.data_exception = exception_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state == RUN);
  assign bus.dbg_state      = state;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 and WIDTH=8, with a reference model
// for the WIDTH=8 random phase.
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [64:0] exp_q[$];
  logic [16:0] exp8_q[$];

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
  seq_divider #(.WIDTH(8),  .CNT_W(4)) dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers, WIDTH=32 ----------------
  task automatic expect32(input logic [31:0] res, input logic [31:0] rem, input logic exc);
    exp_q.push_back({exc, rem, res});
  endtask

  // Called away from the edge; returns #1 after the start edge k.
  task automatic start32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    bus32.ctrl_DIV      = 1'b1;
    bus32.ctrl_SIGNED   = s;
    bus32.data_operandA = a;
    bus32.data_operandB = b;
    @(posedge clock); #1;
    bus32.ctrl_DIV = 1'b0;
    check({tag, "_busy_rise"}, bus32.busy, 1);
  endtask

  task automatic wait_done32(input string tag, input int exp_lat);
    int n;
    logic [64:0] e;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus32.data_resultRDY && n < 200);
    check({tag, "_latency"}, n, exp_lat);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, bus32.data_result, e[31:0]);
      check({tag, "_remainder"}, bus32.data_remainder, e[63:32]);
      check({tag, "_exception"}, bus32.data_exception, e[64]);
      check({tag, "_busy_low"}, bus32.busy, 0);
    end
  endtask

  task automatic pulse_end32(input string tag);
    @(posedge clock); #1;
    check({tag, "_rdy_one_cycle"}, bus32.data_resultRDY, 0);
    check({tag, "_idle"}, bus32.dbg_state, 2'd0);
  endtask

  // ---------------- drivers, WIDTH=8 ----------------
  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    bus8.ctrl_DIV      = 1'b1;
    bus8.ctrl_SIGNED   = s;
    bus8.data_operandA = a;
    bus8.data_operandB = b;
    @(posedge clock); #1;
    bus8.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input int exp_lat);
    int n;
    logic [16:0] e;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!bus8.data_resultRDY && n < 100);
    check({tag, "_latency"}, n, exp_lat);
    if (exp8_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp8_q.pop_front();
      check({tag, "_result"}, bus8.data_result, e[7:0]);
      check({tag, "_remainder"}, bus8.data_remainder, e[15:8]);
      check({tag, "_exception"}, bus8.data_exception, e[16]);
    end
  endtask

  // Reference: {exception, remainder, quotient}
  function automatic logic [16:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa, sb, sq, sr;
    if (b == 8'h00) return {1'b1, a, 8'hFF};
    if (s && a == 8'h80 && b == 8'hFF) return {1'b1, 8'h00, a};
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sr, sq};
    end
    return {1'b0, a % b, a / b};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int seen_rdy;
    logic s;
    logic [7:0] ra, rb;
    logic [16:0] m;

    bus32.ctrl_DIV = 1'b0; bus32.ctrl_SIGNED = 1'b0;
    bus32.data_operandA = '0; bus32.data_operandB = '0;
    bus8.ctrl_DIV = 1'b0; bus8.ctrl_SIGNED = 1'b0;
    bus8.data_operandA = '0; bus8.data_operandB = '0;

    // Reset values, before any clock edge
    #2;
    check("rst_busy", bus32.busy, 0);
    check("rst_rdy", bus32.data_resultRDY, 0);
    check("rst_exc", bus32.data_exception, 0);
    check("rst_result", bus32.data_result, 0);
    check("rst_remainder", bus32.data_remainder, 0);
    check("rst_state", bus32.dbg_state, 2'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Signed 100 / 7
    expect32(32'd14, 32'd2, 1'b0);
    start32("s100_7", 1'b1, 32'd100, 32'd7);
    check("s100_7_run_state", bus32.dbg_state, 2'd1);
    wait_done32("s100_7", 33);
    pulse_end32("s100_7");

    // Signed -100 / 7
    expect32(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    start32("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done32("sm100_7", 33);

    // 0xFFFFFFFF / 2, unsigned then signed
    expect32(32'h7FFF_FFFF, 32'd1, 1'b0);
    start32("u_ff_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_done32("u_ff_2", 33);
    expect32(32'd0, 32'hFFFF_FFFF, 1'b0);
    start32("s_ff_2", 1'b1, 32'hFFFF_FFFF, 32'd2);
    wait_done32("s_ff_2", 33);

    // Divide by zero and signed overflow finish one edge after start
    expect32(32'hFFFF_FFFF, 32'd1234, 1'b1);
    start32("div0", 1'b0, 32'd1234, 32'd0);
    wait_done32("div0", 1);
    pulse_end32("div0");
    expect32(32'h8000_0000, 32'd0, 1'b1);
    start32("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32("ovf", 1);

    // Zero dividend
    expect32(32'd0, 32'd0, 1'b0);
    start32("zero_a", 1'b0, 32'd0, 32'd5);
    wait_done32("zero_a", 33);

    // Second request at k+5 is ignored; outputs hold during RUN
    expect32(32'hFFFF_FEB3, 32'd1, 1'b0);
    start32("ignore", 1'b1, 32'd1000, 32'hFFFF_FFFD);
    repeat (4) @(posedge clock);
    #1;
    check("ignore_hold_result", bus32.data_result, 0);
    bus32.ctrl_DIV = 1'b1;
    bus32.ctrl_SIGNED = 1'b0;
    bus32.data_operandA = 32'd50;
    bus32.data_operandB = 32'd5;
    @(posedge clock); #1;
    bus32.ctrl_DIV = 1'b0;
    check("ignore_still_run", bus32.dbg_state, 2'd1);
    wait_done32("ignore", 28);
    pulse_end32("ignore");

    // Back-to-back: request held high on the cycle data_resultRDY is high
    expect32(32'd22, 32'd2, 1'b0);
    start32("b2b_first", 1'b0, 32'd200, 32'd9);
    wait_done32("b2b_first", 33);
    expect32(32'd1, 32'd0, 1'b0);
    start32("b2b_second", 1'b0, 32'd7, 32'd7);
    check("b2b_rdy_dropped", bus32.data_resultRDY, 0);
    wait_done32("b2b_second", 33);

    // Reset at k+10 aborts without a completion pulse
    start32("abort", 1'b0, 32'd12345, 32'd10);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", bus32.busy, 0);
    check("abort_result", bus32.data_result, 0);
    check("abort_remainder", bus32.data_remainder, 0);
    check("abort_state", bus32.dbg_state, 2'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    seen_rdy = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus32.data_resultRDY) seen_rdy++;
    end
    check("abort_no_rdy", seen_rdy, 0);

    // Fresh operation after reset
    expect32(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    start32("after_rst", 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done32("after_rst", 33);

    // WIDTH=8: signed -128 / 3
    exp8_q.push_back({1'b0, 8'hFE, 8'hD6});
    start8(1'b1, 8'h80, 8'd3);
    wait_done8("w8_m128_3", 9);

    // WIDTH=8 random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 5) rb = 8'h00;
      if (i == 9) begin s = 1'b1; ra = 8'h80; rb = 8'hFF; end
      m = ref8(s, ra, rb);
      exp8_q.push_back(m);
      start8(s, ra, rb);
      wait_done8($sformatf("w8_rand%0d", i), m[16] ? 1 : 9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
